// File: rtl/motion_estimator.sv
// Full-search block matcher: fetches an 8x8 block and a 24x24 window, scores all 17x17
// displacements one per cycle, and reports the minimum SAD and its position per block.
module motion_estimator #(
    parameter int CUR_WORDS = 16,
    parameter int REF_WORDS = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [31:0] cur_in_i,
    input  logic [63:0] ref_in_i,
    output logic [31:0] cur_mem_addr,
    output logic [31:0] ref_mem_addr,
    output logic        cur_mem_en,
    output logic        ref_mem_en,
    output logic [13:0] MSAD,
    output logic [4:0]  MSAD_column,
    output logic [4:0]  MSAD_row,
    output logic        data_valid
);
    localparam int BLK  = 8;
    localparam int WIN  = 24;
    localparam int MAXD = WIN - BLK;

    typedef enum logic [2:0] {IDLE, LOAD_CUR, LOAD_REF, SEARCH, DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [4:0]  r_q, r_d, c_q, c_d;
    logic [31:0] blk_q, blk_d;
    logic [31:0] cur_addr_q, cur_addr_d, ref_addr_q, ref_addr_d;
    logic        cur_en_q, cur_en_d, ref_en_q, ref_en_d;
    logic [13:0] min_sad_q, min_sad_d;
    logic [4:0]  min_r_q, min_r_d, min_c_q, min_c_d;
    logic [13:0] msad_q, msad_d;
    logic [4:0]  msad_r_q, msad_r_d, msad_c_q, msad_c_d;
    logic        dv_q, dv_d;
    logic [7:0]  cur_pix_q [BLK*BLK];
    logic [7:0]  cur_pix_d [BLK*BLK];
    logic [7:0]  ref_pix_q [WIN*WIN];
    logic [7:0]  ref_pix_d [WIN*WIN];
    logic [13:0] sad;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // SAD of the candidate at displacement (r_q, c_q), evaluated in a single cycle
    always_comb begin
        sad = '0;
        for (int y = 0; y < BLK; y++) begin
            for (int x = 0; x < BLK; x++) begin
                sad = sad + {6'd0, abs_diff(cur_pix_q[6'(y*BLK + x)],
                                            ref_pix_q[10'((y + int'(r_q)) * WIN + x + int'(c_q))])};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        c_d        = c_q;
        blk_d      = blk_q;
        cur_addr_d = cur_addr_q;
        ref_addr_d = ref_addr_q;
        cur_en_d   = 1'b0;
        ref_en_d   = 1'b0;
        min_sad_d  = min_sad_q;
        min_r_d    = min_r_q;
        min_c_d    = min_c_q;
        msad_d     = msad_q;
        msad_r_d   = msad_r_q;
        msad_c_d   = msad_c_q;
        dv_d       = 1'b0;
        cur_pix_d  = cur_pix_q;
        ref_pix_d  = ref_pix_q;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d    = LOAD_CUR;
                    cnt_d      = '0;
                    cur_en_d   = 1'b1;
                    cur_addr_d = blk_q * 32'(CUR_WORDS);
                end
            end
            LOAD_CUR: begin
                for (int k = 0; k < 4; k++) begin
                    cur_pix_d[6'(4*int'(cnt_q) + k)] = cur_in_i[8*k +: 8];
                end
                if (cnt_q == 7'(CUR_WORDS - 1)) begin
                    state_d    = LOAD_REF;
                    cnt_d      = '0;
                    ref_en_d   = 1'b1;
                    ref_addr_d = blk_q * 32'(REF_WORDS);
                end else begin
                    cnt_d      = cnt_q + 7'd1;
                    cur_en_d   = 1'b1;
                    cur_addr_d = cur_addr_q + 32'd1;
                end
            end
            LOAD_REF: begin
                for (int k = 0; k < 8; k++) begin
                    ref_pix_d[10'(8*int'(cnt_q) + k)] = ref_in_i[8*k +: 8];
                end
                if (cnt_q == 7'(REF_WORDS - 1)) begin
                    state_d = SEARCH;
                    r_d     = '0;
                    c_d     = '0;
                end else begin
                    cnt_d      = cnt_q + 7'd1;
                    ref_en_d   = 1'b1;
                    ref_addr_d = ref_addr_q + 32'd1;
                end
            end
            SEARCH: begin
                // strict compare keeps the earliest candidate in raster order on ties
                if ((r_q == '0 && c_q == '0) || sad < min_sad_q) begin
                    min_sad_d = sad;
                    min_r_d   = r_q;
                    min_c_d   = c_q;
                end
                if (c_q == 5'(MAXD)) begin
                    c_d = '0;
                    if (r_q == 5'(MAXD)) begin
                        state_d = DONE;
                    end else begin
                        r_d = r_q + 5'd1;
                    end
                end else begin
                    c_d = c_q + 5'd1;
                end
            end
            DONE: begin
                msad_d   = min_sad_q;
                msad_r_d = min_r_q;
                msad_c_d = min_c_q;
                dv_d     = 1'b1;
                blk_d    = blk_q + 32'd1;
                if (en_i) begin
                    state_d    = LOAD_CUR;
                    cnt_d      = '0;
                    cur_en_d   = 1'b1;
                    cur_addr_d = blk_d * 32'(CUR_WORDS);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            c_q        <= '0;
            blk_q      <= '0;
            cur_addr_q <= '0;
            ref_addr_q <= '0;
            cur_en_q   <= 1'b0;
            ref_en_q   <= 1'b0;
            min_sad_q  <= '0;
            min_r_q    <= '0;
            min_c_q    <= '0;
            msad_q     <= '0;
            msad_r_q   <= '0;
            msad_c_q   <= '0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            c_q        <= c_d;
            blk_q      <= blk_d;
            cur_addr_q <= cur_addr_d;
            ref_addr_q <= ref_addr_d;
            cur_en_q   <= cur_en_d;
            ref_en_q   <= ref_en_d;
            min_sad_q  <= min_sad_d;
            min_r_q    <= min_r_d;
            min_c_q    <= min_c_d;
            msad_q     <= msad_d;
            msad_r_q   <= msad_r_d;
            msad_c_q   <= msad_c_d;
            dv_q       <= dv_d;
        end
    end

    // pixel buffers are always fully reloaded before use, so they need no reset
    always_ff @(posedge clk) begin
        cur_pix_q <= cur_pix_d;
        ref_pix_q <= ref_pix_d;
    end

    assign cur_mem_addr = cur_addr_q;
    assign ref_mem_addr = ref_addr_q;
    assign cur_mem_en   = cur_en_q;
    assign ref_mem_en   = ref_en_q;
    assign MSAD         = msad_q;
    assign MSAD_row     = msad_r_q;
    assign MSAD_column  = msad_c_q;
    assign data_valid   = dv_q;
endmodule

// File: tb/tb_motion_estimator.sv
// Bench for motion_estimator: combinational frame memories, table of block patterns,
// scoreboard of expected minima, address/period monitor, mid-search reset.
module tb_motion_estimator;
    localparam int NBLK = 6;

    logic        clk = 1'b0;
    logic        rst, en_i;
    logic [31:0] cur_in_i;
    logic [63:0] ref_in_i;
    logic [31:0] cur_mem_addr, ref_mem_addr;
    logic        cur_mem_en, ref_mem_en;
    logic [13:0] MSAD;
    logic [4:0]  MSAD_column, MSAD_row;
    logic        data_valid;

    always #5 clk = ~clk;

    motion_estimator dut (
        .clk(clk), .rst(rst), .en_i(en_i),
        .cur_in_i(cur_in_i), .ref_in_i(ref_in_i),
        .cur_mem_addr(cur_mem_addr), .ref_mem_addr(ref_mem_addr),
        .cur_mem_en(cur_mem_en), .ref_mem_en(ref_mem_en),
        .MSAD(MSAD), .MSAD_column(MSAD_column), .MSAD_row(MSAD_row),
        .data_valid(data_valid)
    );

    logic [31:0] cur_mem [NBLK*16];
    logic [63:0] ref_mem [NBLK*72];
    logic [7:0]  cur_px  [NBLK][64];
    logic [7:0]  ref_px  [NBLK][576];

    always_comb begin
        cur_in_i = '0;
        if (cur_mem_addr < 32'(NBLK*16)) cur_in_i = cur_mem[cur_mem_addr[6:0]];
    end
    always_comb begin
        ref_in_i = '0;
        if (ref_mem_addr < 32'(NBLK*72)) ref_in_i = ref_mem[ref_mem_addr[8:0]];
    end

    // cur_kind: 0 ramp, 1 all 0x00, 2 all 0x40, 3 random
    // ref_kind: 0 0xFF with copies of cur at (r0,c0) and (r1,c1) if r1>=0, 1 all 0xFF, 2 all 0x40, 3 random
    typedef struct {
        int cur_kind; int ref_kind;
        int r0; int c0; int r1; int c1;
        int exp_sad; int exp_row; int exp_col;
    } vec_t;
    typedef struct { int sad; int row; int col; } exp_t;

    vec_t vecs [NBLK];
    exp_t sb [$];
    exp_t mon_e;

    int n_chk = 0, n_fail = 0;
    int dv_count = 0, cyc = 0, last_dv = -1;
    int exp_cur_addr = 0, exp_ref_addr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string p);
        check({p, "_cur_addr"}, cur_mem_addr, 0);
        check({p, "_ref_addr"}, ref_mem_addr, 0);
        check({p, "_cur_en"},   cur_mem_en,   0);
        check({p, "_ref_en"},   ref_mem_en,   0);
        check({p, "_msad"},     MSAD,         0);
        check({p, "_row"},      MSAD_row,     0);
        check({p, "_col"},      MSAD_column,  0);
        check({p, "_dv"},       data_valid,   0);
    endtask

    task automatic place(input int b, input int r, input int c);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                ref_px[b][(y + r)*24 + x + c] = cur_px[b][y*8 + x];
    endtask

    task automatic model(input int b, output exp_t e);
        int s, a, d;
        e.sad = -1; e.row = 0; e.col = 0;
        for (int r = 0; r <= 16; r++) begin
            for (int c = 0; c <= 16; c++) begin
                s = 0;
                for (int y = 0; y < 8; y++) begin
                    for (int x = 0; x < 8; x++) begin
                        a = int'(cur_px[b][y*8 + x]);
                        d = int'(ref_px[b][(y + r)*24 + x + c]);
                        s += (a > d) ? a - d : d - a;
                    end
                end
                if (e.sad < 0 || s < e.sad) begin
                    e.sad = s; e.row = r; e.col = c;
                end
            end
        end
    endtask

    task automatic build_block(input int b, input vec_t v);
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            case (v.cur_kind)
                0:       cur_px[b][i] = 8'(i);
                1:       cur_px[b][i] = 8'h00;
                2:       cur_px[b][i] = 8'h40;
                default: cur_px[b][i] = 8'($urandom);
            endcase
        end
        for (int i = 0; i < 576; i++) begin
            case (v.ref_kind)
                2:       ref_px[b][i] = 8'h40;
                3:       ref_px[b][i] = 8'($urandom);
                default: ref_px[b][i] = 8'hFF;
            endcase
        end
        if (v.ref_kind == 0) begin
            place(b, v.r0, v.c0);
            if (v.r1 >= 0) place(b, v.r1, v.c1);
        end
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                cur_mem[b*16 + y*2 + x/4][8*(x%4) +: 8] = cur_px[b][y*8 + x];
        for (int y = 0; y < 24; y++)
            for (int x = 0; x < 24; x++)
                ref_mem[b*72 + y*3 + x/8][8*(x%8) +: 8] = ref_px[b][y*24 + x];
        if (v.exp_sad < 0) model(b, e);
        else e = '{sad: v.exp_sad, row: v.exp_row, col: v.exp_col};
        sb.push_back(e);
    endtask

    // Monitor: address sequencing, enable exclusivity, results against the scoreboard
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            cyc++;
            if (cur_mem_en) begin
                check("cur_addr_seq", cur_mem_addr, exp_cur_addr);
                exp_cur_addr++;
            end
            if (ref_mem_en) begin
                check("ref_addr_seq", ref_mem_addr, exp_ref_addr);
                exp_ref_addr++;
            end
            if (cur_mem_en && ref_mem_en) check("en_exclusive", 1, 0);
            if (data_valid) begin
                dv_count++;
                if (sb.size() == 0) begin
                    check("unexpected_dv", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("msad", MSAD, mon_e.sad);
                    check("msad_row", MSAD_row, mon_e.row);
                    check("msad_col", MSAD_column, mon_e.col);
                end
                if (last_dv >= 0) check("dv_period", cyc - last_dv, 378);
                last_dv = cyc;
            end
        end
    end

    // Called right after en_i is raised at +1; the next edge samples it in IDLE.
    // The pulse occupies the 379th cycle after that edge, i.e. it is seen after edge 378.
    task automatic measure_first(input string name);
        int n;
        n = 0;
        @(posedge clk); #1;
        check({name, "_first_cur_en"}, cur_mem_en, 1);
        check({name, "_first_cur_addr"}, cur_mem_addr, 0);
        while (!data_valid && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, n, 378);
    endtask

    task automatic wait_dv(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (dv_count < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_pulses"}, dv_count, target);
    endtask

    initial begin
        rst  = 1'b1;
        en_i = 1'b0;
        vecs[0] = '{cur_kind: 0, ref_kind: 0, r0: 3,  c0: 5,  r1: -1, c1: 0, exp_sad: 0,     exp_row: 3,  exp_col: 5};
        vecs[1] = '{cur_kind: 1, ref_kind: 1, r0: 0,  c0: 0,  r1: -1, c1: 0, exp_sad: 16320, exp_row: 0,  exp_col: 0};
        vecs[2] = '{cur_kind: 2, ref_kind: 2, r0: 0,  c0: 0,  r1: -1, c1: 0, exp_sad: 0,     exp_row: 0,  exp_col: 0};
        vecs[3] = '{cur_kind: 0, ref_kind: 0, r0: 16, c0: 16, r1: -1, c1: 0, exp_sad: 0,     exp_row: 16, exp_col: 16};
        vecs[4] = '{cur_kind: 0, ref_kind: 0, r0: 10, c0: 7,  r1: 2,  c1: 2, exp_sad: 0,     exp_row: 2,  exp_col: 2};
        vecs[5] = '{cur_kind: 3, ref_kind: 3, r0: 0,  c0: 0,  r1: -1, c1: 0, exp_sad: -1,    exp_row: 0,  exp_col: 0};
        for (int b = 0; b < NBLK; b++) build_block(b, vecs[b]);

        repeat (5) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            check("idle_cur_en", cur_mem_en, 0);
            check("idle_ref_en", ref_mem_en, 0);
            check("idle_dv", data_valid, 0);
        end
        check("idle_msad", MSAD, 0);

        // Back-to-back blocks; en_i dropped mid-way through the last one
        en_i = 1'b1;
        measure_first("run");
        wait_dv(5, 5*400, "run");
        repeat (100) @(posedge clk);
        #1;
        en_i = 1'b0;
        wait_dv(6, 400, "last_block");
        repeat (30) @(posedge clk);
        #1;
        check("after_cur_en", cur_mem_en, 0);
        check("after_ref_en", ref_mem_en, 0);
        check("after_pulses", dv_count, 6);
        check("hold_cur_addr", cur_mem_addr, 95);
        check("hold_ref_addr", ref_mem_addr, 431);
        check("cur_words_total", exp_cur_addr, 96);
        check("ref_words_total", exp_ref_addr, 432);
        check("sb_drained", sb.size(), 0);

        // Reset during SEARCH of block 6, then restart from block 0
        en_i = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("mid_rst");
        exp_cur_addr = 0;
        exp_ref_addr = 0;
        last_dv      = -1;
        sb.push_back('{sad: 0, row: 3, col: 5});
        rst = 1'b0;
        measure_first("restart");
        repeat (3) @(posedge clk);
        #1;
        check("restart_pulses", dv_count, 7);
        check("restart_sb", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
